// File: rtl/cs_sub_pipe_pkg.sv
// Shared constants and the per-stage pipeline record for the carry-select
// subtractor. Stage records shift operand and result bytes right by one slice
// per stage, so the slice being resolved always sits in the low byte.
package cs_sub_pipe_pkg;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSTAGE = 4;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] res;     // resolved bytes collect at the top, shifting down
    logic [WIDTH-1:0] a_hi;    // unresolved minuend bytes, next slice in [SLICE-1:0]
    logic [WIDTH-1:0] b_hi;    // unresolved subtrahend bytes
    logic             borrow;  // borrow out of the previous slice (bin for stage 0)
    logic             sa;      // minuend sign, carried for overflow
    logic             sb;      // subtrahend sign, carried for overflow
  } stage_t;

endpackage

// File: rtl/cs_sub_pipe_if.sv
// Operand/result handshake bundle for cs_sub_pipe.
// slave is the subtractor's view, master is the producer/consumer view.
interface cs_sub_pipe_if;
  import cs_sub_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ov;
  logic             zf;
  logic             nf;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ov, zf, nf
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ov, zf, nf
  );

endinterface

// File: rtl/cs_sub_pipe_sub8_slice.sv
// One slice of the subtractor: a - b - bin over SLICE bits, with borrow out.
// The extra top bit of the widened difference is set exactly when a < b + bin.
module sub8_slice
  import cs_sub_pipe_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] diff,
  output logic             bout
);

  logic [SLICE:0] full;

  assign full = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
  assign diff = full[SLICE-1:0];
  assign bout = full[SLICE];

endmodule

// File: rtl/cs_sub_pipe.sv
// Pipelined carry-select subtractor: d = a - b - bin, one slice per stage.
// Stage k holds operands with slices 0..k-1 resolved; both borrow-in
// candidates for slice k are formed and the held borrow picks one. A final
// output register holds the finished result, so latency is NSTAGE cycles.
// Optional build macro CS_SUB_FLAGS_EN adds registered zero/negative flags;
// without it zf and nf are tied low.
module cs_sub_pipe
  import cs_sub_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  cs_sub_pipe_if.slave   bus
);

  stage_t           st [NSTAGE];
  stage_t           nx [NSTAGE];
  logic [SLICE-1:0] dif0 [NSTAGE];
  logic [SLICE-1:0] dif1 [NSTAGE];
  logic             bo0 [NSTAGE];
  logic             bo1 [NSTAGE];
  logic [NSTAGE:0]  rdy;

  logic             out_valid_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ov_q;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_slice
    sub8_slice u_b0 (
      .a    (st[k].a_hi[SLICE-1:0]),
      .b    (st[k].b_hi[SLICE-1:0]),
      .bin  (1'b0),
      .diff (dif0[k]),
      .bout (bo0[k])
    );
    sub8_slice u_b1 (
      .a    (st[k].a_hi[SLICE-1:0]),
      .b    (st[k].b_hi[SLICE-1:0]),
      .bin  (1'b1),
      .diff (dif1[k]),
      .bout (bo1[k])
    );
  end

  // Resolve each stage's slice by selecting the candidate matching its borrow.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      nx[k]        = st[k];
      nx[k].res    = {(st[k].borrow ? dif1[k] : dif0[k]), st[k].res[WIDTH-1:SLICE]};
      nx[k].a_hi   = st[k].a_hi >> SLICE;
      nx[k].b_hi   = st[k].b_hi >> SLICE;
      nx[k].borrow = st[k].borrow ? bo1[k] : bo0[k];
    end
  end

  // Ready chain: a stage may load when it is empty or everything below it moves.
  always_comb begin : ready_chain
    logic acc;
    rdy         = '0;
    acc         = !out_valid_q || bus.out_ready;
    rdy[NSTAGE] = acc;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      acc    = !st[k].valid || acc;
      rdy[k] = acc;
    end
  end

  assign bus.in_ready = rdy[0];

  // Stage registers: capture operands at stage 0, pass resolved records downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) st[k] <= '0;
    end else begin
      if (rdy[0]) begin
        if (bus.in_valid)
          st[0] <= '{valid: 1'b1, res: '0, a_hi: bus.a, b_hi: bus.b,
                     borrow: bus.bin, sa: bus.a[WIDTH-1], sb: bus.b[WIDTH-1]};
        else
          st[0].valid <= 1'b0;
      end
      for (int k = 1; k < NSTAGE; k++) begin
        if (rdy[k]) begin
          if (st[k-1].valid) st[k] <= nx[k-1];
          else               st[k].valid <= 1'b0;
        end
      end
    end
  end

  // Output register: finished difference, borrow and overflow, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      ov_q        <= 1'b0;
    end else if (rdy[NSTAGE]) begin
      out_valid_q <= st[NSTAGE-1].valid;
      if (st[NSTAGE-1].valid) begin
        d_q    <= nx[NSTAGE-1].res;
        bout_q <= nx[NSTAGE-1].borrow;
        ov_q   <= (st[NSTAGE-1].sa ^ st[NSTAGE-1].sb) &
                  (st[NSTAGE-1].sa ^ nx[NSTAGE-1].res[WIDTH-1]);
      end
    end
  end

`ifdef CS_SUB_FLAGS_EN
  logic zf_q;
  logic nf_q;

  // Flags are registered alongside the result they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      nf_q <= 1'b0;
    end else if (rdy[NSTAGE] && st[NSTAGE-1].valid) begin
      zf_q <= (nx[NSTAGE-1].res == '0);
      nf_q <= nx[NSTAGE-1].res[WIDTH-1];
    end
  end

  assign bus.zf = zf_q;
  assign bus.nf = nf_q;
`else
  assign bus.zf = 1'b0;
  assign bus.nf = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
  assign bus.ov        = ov_q;

  // Operand bytes of the last stage and the zero fill of stage 0 are never consumed.
  logic unused_bits;
  assign unused_bits = ^{nx[NSTAGE-1].valid, nx[NSTAGE-1].a_hi, nx[NSTAGE-1].b_hi,
                         nx[NSTAGE-1].sa, nx[NSTAGE-1].sb, st[0].res[SLICE-1:0]};

endmodule

// File: tb/tb_cs_sub_pipe.sv
// Scoreboard bench for cs_sub_pipe: expected results are queued on accept and
// compared in order on every output transfer.
module tb_cs_sub_pipe;
  import cs_sub_pipe_pkg::*;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ov;
    logic             zf;
    logic             nf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cs_sub_pipe_if bus ();

  cs_sub_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    exp_t        e;
    logic [WIDTH:0] f;
    f      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    e.d    = f[WIDTH-1:0];
    e.bout = f[WIDTH];
    e.ov   = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ e.d[WIDTH-1]);
`ifdef CS_SUB_FLAGS_EN
    e.zf   = (e.d == '0);
    e.nf   = e.d[WIDTH-1];
`else
    e.zf   = 1'b0;
    e.nf   = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.a, bus.b, bus.bin));
      if (bus.out_valid && bus.out_ready) begin
        check("out_has_pending_op", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("d",    bus.d,    e.d);
          check("bout", bus.bout, e.bout);
          check("ov",   bus.ov,   e.ov);
          check("zf",   bus.zf,   e.zf);
          check("nf",   bus.nf,   e.nf);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One unstalled operation on an empty pipe; returns cycles from accept to out_valid.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, output int lat);
    int g;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("accept_in_time", g < 50, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] da [6] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h0100_0000, 32'h1234_5678};
  logic [WIDTH-1:0] db [6] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001,
                               32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678};
  logic             dbin [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int lat;
    int k;
    int i;
    int g;
    logic saw_stall;
    logic [WIDTH-1:0] ta [8];
    logic [WIDTH-1:0] tb [8];

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_d",         bus.d,         0);
    check("rst_bout",      bus.bout,      0);
    check("rst_ov",        bus.ov,        0);
    check("rst_zf",        bus.zf,        0);
    check("rst_nf",        bus.nf,        0);
    check("rst_in_ready",  bus.in_ready,  1);
    @(posedge clk);
    #1;

    // Directed corner cases, one at a time on an empty pipe.
    for (int n = 0; n < 6; n++) begin
      run_op(da[n], db[n], dbin[n], lat);
      check("latency", lat, 4);
    end

    // Back-to-back burst with the consumer stalled for cycles 3..9.
    for (int n = 0; n < 8; n++) begin
      ta[n] = $urandom;
      tb[n] = $urandom;
    end
    k = 0;
    i = 0;
    saw_stall = 1'b0;
    while ((k < 8 || sb_q.size() > 0) && i < 100) begin
      bus.out_ready = !(i >= 3 && i <= 9);
      bus.in_valid  = (k < 8);
      bus.a         = ta[k % 8];
      bus.b         = tb[k % 8];
      bus.bin       = k[0];
      @(negedge clk);
      if (!bus.in_ready) saw_stall = 1'b1;
      if (i >= 10 && k < 8) check("full_rate_after_stall", bus.in_ready, 1);
      if (bus.in_valid && bus.in_ready) k++;
      @(posedge clk);
      #1;
      i++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("burst_stalled_input", saw_stall, 1);
    check("burst_all_accepted", k, 8);
    check("burst_drained", sb_q.size(), 0);

    // Random valid/ready traffic.
    for (int n = 0; n < 200; n++) begin
      bus.in_valid  = $urandom_range(0, 1);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.a         = $urandom;
      bus.b         = ($urandom_range(0, 3) == 0) ? bus.a : $urandom;
      bus.bin       = $urandom_range(0, 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    g = 0;
    while (sb_q.size() > 0 && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("random_drained", sb_q.size(), 0);

    // Reset with three operations in flight and a simultaneous input.
    for (int n = 0; n < 3; n++) begin
      bus.in_valid = 1'b1;
      bus.a        = 32'h100 + n;
      bus.b        = 32'h1;
      bus.bin      = 1'b0;
      @(posedge clk);
      #1;
    end
    rst     = 1'b1;
    bus.a   = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("post_rst_out_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    run_op(32'd10, 32'd4, 1'b0, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
